// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply-divide unit that owns the HI/LO register pair.
// Radix-2 shift-add multiply, restoring divide, then a one-cycle sign-fixup stage.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } state_t;

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           next_state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] opnd;
   logic             neg_res;
   logic             neg_rem;
   logic             is_div;

   logic             signed_op;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             is_mul_op;
   logic             is_div_op;
   logic             div_zero;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign busy = (state != S_IDLE);

   assign signed_op = ~op[0];
   assign a_neg     = signed_op & opA[WIDTH-1];
   assign b_neg     = signed_op & opB[WIDTH-1];
   assign a_mag     = a_neg ? -opA : opA;
   assign b_mag     = b_neg ? -opB : opB;
   assign is_mul_op = (op[2:1] == 2'b00);
   assign is_div_op = (op[2:1] == 2'b01);
   assign div_zero  = (opB == '0);

   // Multiply: acc_hi is the running upper half, acc_lo shifts the multiplier out
   // while the product's low bits shift in from the top.
   assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

   // Divide: acc_hi is the partial remainder, acc_lo shifts the dividend out
   // while quotient bits shift in at the bottom.
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd};

   assign product  = {acc_hi, acc_lo};
   assign prod_fix = neg_res ? -product : product;
   assign quo_fix  = neg_res ? -acc_lo : acc_lo;
   assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (is_mul_op)                   next_state = S_MUL;
               else if (is_div_op && !div_zero) next_state = S_DIV;
            end
         end
         S_MUL:   if (cnt == LAST) next_state = S_FIX;
         S_DIV:   if (cnt == LAST) next_state = S_FIX;
         S_FIX:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
      if (flush) next_state = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         opnd    <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         is_div  <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!flush) begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     if (op == 3'b100) hi <= opA;
                     if (op == 3'b101) lo <= opA;
                     if (is_mul_op) begin
                        acc_hi  <= '0;
                        acc_lo  <= b_mag;
                        opnd    <= a_mag;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= 1'b0;
                        is_div  <= 1'b0;
                        cnt     <= '0;
                     end else if (is_div_op) begin
                        if (div_zero) begin
                           hi   <= opA;
                           lo   <= '1;
                           done <= 1'b1;
                        end else begin
                           acc_hi  <= '0;
                           acc_lo  <= a_mag;
                           opnd    <= b_mag;
                           neg_res <= a_neg ^ b_neg;
                           neg_rem <= a_neg;
                           is_div  <= 1'b1;
                           cnt     <= '0;
                        end
                     end
                  end
               end
               S_MUL: begin
                  acc_hi <= mul_sum[WIDTH:1];
                  acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                  cnt    <= cnt + CW'(1);
               end
               S_DIV: begin
                  // Restore by keeping the unsubtracted value when the trial goes negative.
                  if (!div_diff[WIDTH]) begin
                     acc_hi <= div_diff[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_hi <= div_shift[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                  end
                  cnt <= cnt + CW'(1);
               end
               S_FIX: begin
                  if (is_div) begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end else begin
                     hi <= prod_fix[2*WIDTH-1:WIDTH];
                     lo <= prod_fix[WIDTH-1:0];
                  end
                  done <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus queues expected HI/LO and done cycle,
// a negedge monitor pops and compares whenever done is seen.
module tb_muldiv_unit;
   localparam int unsigned W = 32;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op = '0;
   logic [W-1:0] opA = '0;
   logic [W-1:0] opB = '0;
   logic         flush = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .opA   (opA),
      .opB   (opB),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string        name;
      int unsigned  at;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_done_cycle"}, 64'(cyc), 64'(e.at));
            chk({e.name, "_hi"}, {32'b0, hi}, {32'b0, e.hi});
            chk({e.name, "_lo"}, {32'b0, lo}, {32'b0, e.lo});
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      op = o; opA = a; opB = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic expect_at(input string name, input int unsigned at,
                            input logic [W-1:0] ehi, input logic [W-1:0] elo);
      exp_t e;
      e.name = name; e.at = at; e.hi = ehi; e.lo = elo;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      if (busy) chk({name, "_idle_timeout"}, 64'(busy), 64'(0));
   endtask

   task automatic run(input string name, input logic [2:0] o, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
      issue(o, a, b);
      expect_at(name, cyc + W + 1, ehi, elo);
      @(negedge clk);
      chk({name, "_busy"}, 64'(busy), 64'(1));
      wait_idle(name);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish expected finish before 300000");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      chk("reset_hi", {32'b0, hi}, 64'(0));
      chk("reset_lo", {32'b0, lo}, 64'(0));
      rst_n = 1'b1;

      issue(OP_MTHI, 32'h1357_9BDF, '0);
      chk("mthi_hi", {32'b0, hi}, 64'h1357_9BDF);
      chk("mthi_busy", 64'(busy), 64'(0));
      issue(OP_MTLO, 32'h2468_ACE0, '0);
      chk("mtlo_lo", {32'b0, lo}, 64'h2468_ACE0);
      chk("mtlo_hi_kept", {32'b0, hi}, 64'h1357_9BDF);

      run("mult_m3x7",   OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run("mult_minmin", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      run("mult_minx1",  OP_MULT,  32'h8000_0000, 32'd1,        32'hFFFF_FFFF, 32'h8000_0000);
      run("div_m7d2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run("div_7dm2",    OP_DIV,   32'd7,        32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD);
      run("div_m8dm3",   OP_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2);
      run("divu_7d2",    OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3);
      run("divu_big",    OP_DIVU,  32'hFFFF_FFFF, 32'h10,       32'hF,        32'h0FFF_FFFF);
      run("div_minbym1", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);

      // divide by zero completes without ever raising busy
      issue(OP_DIVU, 32'h1234, 32'd0);
      expect_at("divu_zero", cyc, 32'h1234, 32'hFFFF_FFFF);
      chk("div0_hi_edge", {32'b0, hi}, 64'h1234);
      chk("div0_lo_edge", {32'b0, lo}, 64'hFFFF_FFFF);
      @(negedge clk);
      chk("div0_busy", 64'(busy), 64'(0));

      // reserved op is ignored
      issue(3'b110, 32'd9, 32'd9);
      @(negedge clk);
      chk("op110_busy", 64'(busy), 64'(0));
      chk("op110_hi", {32'b0, hi}, 64'h1234);

      // second start while busy is dropped
      issue(OP_MULTU, 32'd3, 32'd4);
      expect_at("multu_3x4", cyc + W + 1, 32'd0, 32'd12);
      repeat (2) @(negedge clk);
      op = OP_DIVU; opA = 32'd100; opB = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle("multu_3x4");
      repeat (2) @(negedge clk);
      chk("ignored_start_busy", 64'(busy), 64'(0));

      issue(OP_MTHI, 32'hA5A5_A5A5, '0);
      issue(OP_MTLO, 32'h5A5A_5A5A, '0);

      // flush mid-multiply leaves HI/LO untouched and never pulses done
      issue(OP_MULT, 32'd5, 32'd5);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'(0));
      repeat (40) @(negedge clk);
      chk("flush_hi", {32'b0, hi}, 64'hA5A5_A5A5);
      chk("flush_lo", {32'b0, lo}, 64'h5A5A_5A5A);

      // flush beats a simultaneous start
      @(negedge clk);
      op = OP_MTHI; opA = 32'd1; start = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      chk("flush_start_hi", {32'b0, hi}, 64'hA5A5_A5A5);

      // async reset mid-divide
      issue(OP_DIV, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      chk("div_inflight_busy", 64'(busy), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(busy), 64'(0));
      chk("rst_mid_hi", {32'b0, hi}, 64'(0));
      chk("rst_mid_lo", {32'b0, lo}, 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run("mult_6x7", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
